// File: rtl/riscv_exe_branch_resolve_pkg.sv
// Purpose: shared RV32I control-flow encodings, link-register indices and result flag layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_exe_branch_resolve_pkg;

  localparam int RAS_DEPTH_DEF = 8;

  // Opcode / funct3 match patterns for the control-flow instructions.
  localparam logic [31:0] MASK_OPC    = 32'h0000_007F;
  localparam logic [31:0] MASK_JALR   = 32'h0000_707F;
  localparam logic [31:0] INST_JAL    = 32'h0000_006F;
  localparam logic [31:0] INST_JALR   = 32'h0000_0067;
  localparam logic [31:0] INST_BRANCH = 32'h0000_0063;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Registers treated as link registers for call/return hints.
  localparam logic [4:0] X1 = 5'd1;
  localparam logic [4:0] X5 = 5'd5;

  typedef struct packed {
    logic branch;
    logic taken;
    logic call;
    logic ret;
    logic jump;
    logic mispredict;
  } res_flags_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == X1) || (r == X5);
  endfunction

endpackage

// File: rtl/riscv_exe_branch_resolve_ras.sv
// Purpose: circular return-address stack with push, pop and pop-then-push (replace).
// Latency: update at the clock edge, top/valid read combinationally from the updated state.
// Backpressure: none; the caller gates push/pop (stall simply means no push/pop).
module riscv_exe_branch_resolve_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic [XLEN-1:0] top_o,
  output logic            valid_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // ptr indexes the next free slot; the top entry lives at ptr-1.
  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr, ptr_pop, ptr_nxt;
  logic [CW-1:0]   cnt, cnt_pop, cnt_nxt;

  // Pop first (ignored when empty), then push onto the popped state; full push overwrites oldest.
  always_comb begin
    ptr_pop = ptr;
    cnt_pop = cnt;
    if (pop_i && (cnt != '0)) begin
      ptr_pop = ptr - PW'(1);
      cnt_pop = cnt - CW'(1);
    end
    ptr_nxt = ptr_pop;
    cnt_nxt = cnt_pop;
    if (push_i) begin
      ptr_nxt = ptr_pop + PW'(1);
      if (cnt_pop != CW'(DEPTH)) begin
        cnt_nxt = cnt_pop + CW'(1);
      end
    end
  end

  // Stack storage and pointers; reset clears every entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ptr <= ptr_nxt;
      cnt <= cnt_nxt;
      if (push_i) begin
        mem[ptr_pop] <= push_data_i;
      end
    end
  end

  assign valid_o = (cnt != '0);
  assign top_o   = valid_o ? mem[ptr - PW'(1)] : '0;

endmodule

// File: rtl/riscv_exe_branch_resolve.sv
// Purpose: execute-stage RV32I JAL/JALR/Bxx resolution, prediction check and committed RAS.
// Latency: 1 cycle, inputs sampled at edge N appear registered at N+1.
// Backpressure: stall_i freezes all outputs and the RAS; flush_i drops the current input.
module riscv_exe_branch_resolve
  import riscv_exe_branch_resolve_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] ra_data_i,
  input  logic [XLEN-1:0] rb_data_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_target_i,
  output logic            res_valid_o,
  output logic            branch_o,
  output logic            taken_o,
  output logic            call_o,
  output logic            return_o,
  output logic            jump_o,
  output logic [XLEN-1:0] target_o,
  output logic            mispredict_o,
  output logic [XLEN-1:0] next_pc_o,
  output logic [XLEN-1:0] ras_top_o,
  output logic            ras_valid_o
);

  logic            sample;
  logic [4:0]      rd, rs1;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_b, imm_j, imm_i, jalr_sum, pc_plus4;
  logic            is_jal, is_jalr, is_br, br_f3_ok, cond;
  logic [XLEN-1:0] target_d, next_pc_d;
  res_flags_t      flg_d, flg_q;
  logic [XLEN-1:0] target_q, next_pc_q;
  logic            res_valid_q;

  assign sample   = valid_i & ~stall_i & ~flush_i;
  assign rd       = inst_i[11:7];
  assign rs1      = inst_i[19:15];
  assign f3       = inst_i[14:12];
  assign pc_plus4 = pc_i + XLEN'(4);

  assign imm_b = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign jalr_sum = ra_data_i + imm_i;

  // Decode, condition evaluation, target/next-PC and prediction check for the current input.
  always_comb begin
    is_jal   = (inst_i & MASK_OPC) == INST_JAL;
    is_jalr  = (inst_i & MASK_JALR) == INST_JALR;
    br_f3_ok = (f3 != 3'b010) && (f3 != 3'b011);
    is_br    = ((inst_i & MASK_OPC) == INST_BRANCH) && br_f3_ok;

    cond = 1'b0;
    case (f3)
      F3_BEQ:  cond = (ra_data_i == rb_data_i);
      F3_BNE:  cond = (ra_data_i != rb_data_i);
      F3_BLT:  cond = ($signed(ra_data_i) < $signed(rb_data_i));
      F3_BGE:  cond = ($signed(ra_data_i) >= $signed(rb_data_i));
      F3_BLTU: cond = (ra_data_i < rb_data_i);
      F3_BGEU: cond = (ra_data_i >= rb_data_i);
      default: cond = 1'b0;
    endcase

    target_d = '0;
    if (is_jal) begin
      target_d = pc_i + imm_j;
    end else if (is_jalr) begin
      target_d = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (is_br) begin
      target_d = pc_i + imm_b;
    end

    flg_d        = '0;
    flg_d.branch = is_jal | is_jalr | is_br;
    flg_d.jump   = is_jal | is_jalr;
    flg_d.taken  = flg_d.jump | (is_br & cond);
    flg_d.call   = flg_d.jump & is_link(rd);
    flg_d.ret    = is_jalr & is_link(rs1) & ~(is_link(rd) & (rs1 == rd));
    flg_d.mispredict = (flg_d.taken != pred_taken_i) |
                       (flg_d.taken & (target_d != pred_target_i));

    next_pc_d = flg_d.taken ? target_d : pc_plus4;
  end

  // Result register: loads on a sampled input, clears on an unsampled edge, holds on stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      flg_q       <= '0;
      target_q    <= '0;
      next_pc_q   <= '0;
    end else if (!stall_i) begin
      res_valid_q <= sample;
      flg_q       <= sample ? flg_d : '0;
      target_q    <= sample ? target_d : '0;
      next_pc_q   <= sample ? next_pc_d : '0;
    end
  end

  riscv_exe_branch_resolve_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (sample & flg_d.call),
    .pop_i       (sample & flg_d.ret),
    .push_data_i (pc_plus4),
    .top_o       (ras_top_o),
    .valid_o     (ras_valid_o)
  );

  assign res_valid_o  = res_valid_q;
  assign branch_o     = flg_q.branch;
  assign taken_o      = flg_q.taken;
  assign call_o       = flg_q.call;
  assign return_o     = flg_q.ret;
  assign jump_o       = flg_q.jump;
  assign mispredict_o = flg_q.mispredict;
  assign target_o     = target_q;
  assign next_pc_o    = next_pc_q;

endmodule

// File: tb/tb_riscv_exe_branch_resolve.sv
// Purpose: directed self-checking bench for the branch resolution unit.
// Latency: checks outputs 1ns after the edge that samples each vector.
// Backpressure: exercises stall, flush, stall+flush and mid-run reset.
module tb_riscv_exe_branch_resolve;

  logic        clk, rst_n, valid, stall, flush, pt;
  logic [31:0] inst, pc, ra, rb, ptgt;
  logic        res_valid_o, branch_o, taken_o, call_o, return_o, jump_o;
  logic        mispredict_o, ras_valid_o;
  logic [31:0] target_o, next_pc_o, ras_top_o;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_exe_branch_resolve #(.XLEN(32), .RAS_DEPTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_i       (valid),
    .stall_i       (stall),
    .flush_i       (flush),
    .inst_i        (inst),
    .pc_i          (pc),
    .ra_data_i     (ra),
    .rb_data_i     (rb),
    .pred_taken_i  (pt),
    .pred_target_i (ptgt),
    .res_valid_o   (res_valid_o),
    .branch_o      (branch_o),
    .taken_o       (taken_o),
    .call_o        (call_o),
    .return_o      (return_o),
    .jump_o        (jump_o),
    .target_o      (target_o),
    .mispredict_o  (mispredict_o),
    .next_pc_o     (next_pc_o),
    .ras_top_o     (ras_top_o),
    .ras_valid_o   (ras_valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i_inst, input logic [31:0] i_pc,
                       input logic [31:0] i_ra, input logic [31:0] i_rb,
                       input logic i_pt, input logic [31:0] i_ptgt);
    valid = 1'b1;
    inst  = i_inst;
    pc    = i_pc;
    ra    = i_ra;
    rb    = i_rb;
    pt    = i_pt;
    ptgt  = i_ptgt;
    tick();
    valid = 1'b0;
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  // flags packed as {branch, taken, call, return, jump}
  function automatic logic [31:0] flags();
    return 32'({branch_o, taken_o, call_o, return_o, jump_o});
  endfunction

  initial begin
    clk = 0; rst_n = 0; valid = 0; stall = 0; flush = 0; pt = 0;
    inst = 0; pc = 0; ra = 0; rb = 0; ptgt = 0;
    tick();
    tick();
    chk("rst res_valid", 32'(res_valid_o), 32'd0);
    chk("rst flags", flags(), 32'd0);
    chk("rst misp", 32'(mispredict_o), 32'd0);
    chk("rst next_pc", next_pc_o, 32'd0);
    chk("rst ras_valid", 32'(ras_valid_o), 32'd0);
    chk("rst ras_top", ras_top_o, 32'd0);
    rst_n = 1;
    tick();

    // BEQ x1,x2,+16 equal operands, predicted not taken
    drive(enc_b(3'b000, 5'd1, 5'd2, 13'h010), 32'h100, 32'd5, 32'd5, 1'b0, 32'h0);
    chk("beq res_valid", 32'(res_valid_o), 32'd1);
    chk("beq flags", flags(), 32'b11000);
    chk("beq target", target_o, 32'h110);
    chk("beq misp", 32'(mispredict_o), 32'd1);
    chk("beq next_pc", next_pc_o, 32'h110);
    tick();
    chk("idle res_valid", 32'(res_valid_o), 32'd0);
    chk("idle misp", 32'(mispredict_o), 32'd0);

    // BNE equal operands: not taken, correctly predicted
    drive(enc_b(3'b001, 5'd1, 5'd2, 13'h010), 32'h100, 32'd5, 32'd5, 1'b0, 32'h0);
    chk("bne flags", flags(), 32'b10000);
    chk("bne target", target_o, 32'h110);
    chk("bne misp", 32'(mispredict_o), 32'd0);
    chk("bne next_pc", next_pc_o, 32'h104);

    // BLTU 0xFFFFFFFF < 1 unsigned is false
    drive(enc_b(3'b110, 5'd1, 5'd2, 13'h080), 32'h180, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h200);
    chk("bltu flags", flags(), 32'b10000);
    chk("bltu misp", 32'(mispredict_o), 32'd1);
    chk("bltu next_pc", next_pc_o, 32'h184);
    // BLT -1 < 1 signed is true, target matches prediction
    drive(enc_b(3'b100, 5'd1, 5'd2, 13'h040), 32'h1C0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h200);
    chk("blt flags", flags(), 32'b11000);
    chk("blt target", target_o, 32'h200);
    chk("blt misp", 32'(mispredict_o), 32'd0);
    // BGE 1 >= -1 taken, backward offset, wrong predicted target
    drive(enc_b(3'b101, 5'd1, 5'd2, 13'h1F00), 32'h300, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'h204);
    chk("bge target", target_o, 32'h200);
    chk("bge misp", 32'(mispredict_o), 32'd1);
    chk("bge next_pc", next_pc_o, 32'h200);
    // BNE not taken at top of address space: pc+4 wraps to 0
    drive(enc_b(3'b001, 5'd1, 5'd2, 13'h008), 32'hFFFF_FFFC, 32'd7, 32'd7, 1'b1, 32'h4);
    chk("wrap misp", 32'(mispredict_o), 32'd1);
    chk("wrap next_pc", next_pc_o, 32'h0);

    // JAL x1,+8 call then JALR x0,0(x1) return
    drive(enc_j(5'd1, 21'h8), 32'h40, 32'd0, 32'd0, 1'b1, 32'h48);
    chk("jal flags", flags(), 32'b11101);
    chk("jal target", target_o, 32'h48);
    chk("jal misp", 32'(mispredict_o), 32'd0);
    chk("jal ras_top", ras_top_o, 32'h44);
    chk("jal ras_valid", 32'(ras_valid_o), 32'd1);
    drive(enc_i(5'd0, 5'd1, 12'h0), 32'h48, 32'h44, 32'd0, 1'b1, 32'h44);
    chk("ret flags", flags(), 32'b11011);
    chk("ret target", target_o, 32'h44);
    chk("ret misp", 32'(mispredict_o), 32'd0);
    chk("ret ras_valid", 32'(ras_valid_o), 32'd0);
    chk("ret ras_top", ras_top_o, 32'h0);

    // Nine calls into an 8-deep stack, then nine returns
    for (int i = 0; i < 9; i++) begin
      drive(enc_j(5'd1, 21'h8), 32'(4 * i), 32'd0, 32'd0, 1'b1, 32'(4 * i + 8));
      chk("fill top", ras_top_o, 32'(4 * i + 4));
    end
    chk("fill valid", 32'(ras_valid_o), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      drive(enc_i(5'd0, 5'd1, 12'h0), 32'h800, 32'h44, 32'd0, 1'b1, 32'h44);
      chk("drain valid", 32'(ras_valid_o), (k <= 7) ? 32'd1 : 32'd0);
      chk("drain top", ras_top_o, (k <= 7) ? 32'(36 - 4 * k) : 32'd0);
    end

    // Pop-then-push replaces the top without changing depth
    drive(enc_j(5'd1, 21'h8), 32'h600, 32'd0, 32'd0, 1'b1, 32'h608);
    chk("pre top", ras_top_o, 32'h604);
    drive(enc_i(5'd1, 5'd5, 12'h0), 32'h500, 32'h1003, 32'd0, 1'b1, 32'h1002);
    chk("repl flags", flags(), 32'b11111);
    chk("repl target", target_o, 32'h1002);
    chk("repl misp", 32'(mispredict_o), 32'd0);
    chk("repl top", ras_top_o, 32'h504);
    drive(enc_i(5'd1, 5'd1, 12'h0), 32'h700, 32'h20, 32'd0, 1'b1, 32'h20);
    chk("same-link flags", flags(), 32'b11101);
    chk("same-link top", ras_top_o, 32'h704);
    drive(enc_i(5'd0, 5'd1, 12'h0), 32'h720, 32'h704, 32'd0, 1'b1, 32'h704);
    chk("pop1 top", ras_top_o, 32'h504);
    chk("pop1 valid", 32'(ras_valid_o), 32'd1);
    drive(enc_i(5'd0, 5'd1, 12'h0), 32'h724, 32'h504, 32'd0, 1'b1, 32'h504);
    chk("pop2 valid", 32'(ras_valid_o), 32'd0);

    // JALR x0,-4(x6): plain jump, negative immediate
    drive(enc_i(5'd0, 5'd6, 12'hFFC), 32'h730, 32'h10, 32'd0, 1'b0, 32'h0);
    chk("jalr flags", flags(), 32'b11001);
    chk("jalr target", target_o, 32'hC);
    chk("jalr next_pc", next_pc_o, 32'hC);
    // Non-control-flow (ADDI) predicted taken
    drive(32'h0000_0013, 32'h900, 32'd0, 32'd0, 1'b1, 32'h904);
    chk("addi flags", flags(), 32'd0);
    chk("addi target", target_o, 32'd0);
    chk("addi misp", 32'(mispredict_o), 32'd1);
    chk("addi next_pc", next_pc_o, 32'h904);

    // Stall holds outputs for 3 cycles; last one also flushed
    drive(enc_b(3'b000, 5'd1, 5'd2, 13'h010), 32'h100, 32'd5, 32'd5, 1'b0, 32'h0);
    stall = 1; valid = 1; inst = enc_j(5'd1, 21'h8); pc = 32'h10;
    for (int c = 0; c < 3; c++) begin
      flush = (c == 2);
      tick();
      chk("stall res_valid", 32'(res_valid_o), 32'd1);
      chk("stall target", target_o, 32'h110);
      chk("stall misp", 32'(mispredict_o), 32'd1);
      chk("stall ras_valid", 32'(ras_valid_o), 32'd0);
    end
    stall = 0; flush = 1;
    tick();
    chk("flush res_valid", 32'(res_valid_o), 32'd0);
    chk("flush misp", 32'(mispredict_o), 32'd0);
    chk("flush ras_valid", 32'(ras_valid_o), 32'd0);
    flush = 0; valid = 0;
    drive(enc_j(5'd1, 21'h8), 32'h10, 32'd0, 32'd0, 1'b0, 32'h0);
    chk("post call top", ras_top_o, 32'h14);
    chk("post call misp", 32'(mispredict_o), 32'd1);

    // Reset mid-run with stall and a valid input pending
    rst_n = 0; stall = 1; valid = 1;
    tick();
    chk("mrst res_valid", 32'(res_valid_o), 32'd0);
    chk("mrst flags", flags(), 32'd0);
    chk("mrst target", target_o, 32'd0);
    chk("mrst misp", 32'(mispredict_o), 32'd0);
    chk("mrst next_pc", next_pc_o, 32'd0);
    chk("mrst ras_valid", 32'(ras_valid_o), 32'd0);
    chk("mrst ras_top", ras_top_o, 32'd0);
    rst_n = 1; stall = 0; valid = 0;
    tick();
    chk("after rst res_valid", 32'(res_valid_o), 32'd0);
    chk("after rst ras_valid", 32'(ras_valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
